image_bank_sched: RTL



---
 rtl/image_bank_sched_pkg.sv | 15 +
 rtl/image_bank_state.sv | 48 ++++
 rtl/image_bank_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/image_bank_sched_pkg.sv
// Shared image-block config constants and bank-state encodings.
// Used by image_bank_sched (optional re-read feature: IMAGE_BANK_SCHED_REUSE_EN).
package image_bank_sched_pkg;

  localparam logic [4:0] CFG_IMG_WR = 5'd8;
  localparam logic [4:0] CFG_IMG_RD = 5'd9;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/image_bank_state.sv
// Fill/drain state of one image bank: EMPTY -> WRITING -> FULL -> READING -> EMPTY.
// err_pulse flags a done strobe arriving while the bank is not in the matching phase.
module image_bank_state
  import image_bank_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take_wr,
  input  logic        done_wr,
  input  logic        take_rd,
  input  logic        done_rd,
`ifdef IMAGE_BANK_SCHED_REUSE_EN
  input  logic        keep,
`endif
  output bank_state_e state,
  output logic        err_pulse
);

  bank_state_e state_q, state_d;
  logic        drain_to_full;

`ifdef IMAGE_BANK_SCHED_REUSE_EN
  assign drain_to_full = keep;
`else
  assign drain_to_full = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    err_pulse = (done_wr && (state_q != BANK_WRITING)) ||
                (done_rd && (state_q != BANK_READING));
    case (state_q)
      BANK_EMPTY:   if (take_wr) state_d = BANK_WRITING;
      BANK_WRITING: if (done_wr) state_d = BANK_FULL;
      BANK_FULL:    if (take_rd) state_d = BANK_READING;
      BANK_READING: if (done_rd) state_d = drain_to_full ? BANK_FULL : BANK_EMPTY;
      default:      state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= BANK_EMPTY;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/image_bank_sched.sv
// Ping-pong m0/m1 bank scheduler: grants banks to producer/consumer and issues CFG_IMG_WR/RD words.
// Optional IMAGE_BANK_SCHED_REUSE_EN adds rd_keep to re-read the same image instead of draining it.
module image_bank_sched
  import image_bank_sched_pkg::*;
#(
  parameter int                    CFG_DWIDTH  = 32,
  parameter int                    CFG_AWIDTH  = 5,
  parameter logic [CFG_AWIDTH-1:0] WR_CFG_ADDR = CFG_AWIDTH'(CFG_IMG_WR),
  parameter logic [CFG_AWIDTH-1:0] RD_CFG_ADDR = CFG_AWIDTH'(CFG_IMG_RD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_grant,
  output logic                  wr_bank,
  input  logic                  wr_done,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic                  rd_bank,
  input  logic                  rd_done,
`ifdef IMAGE_BANK_SCHED_REUSE_EN
  input  logic                  rd_keep,
`endif
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  output logic [1:0]            bank_full,
  output logic                  err
);

  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  rd_prio_q, rd_prio_d;
  logic                  wr_grant_q, wr_grant_d;
  logic                  rd_grant_q, rd_grant_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
  logic                  err_q, err_d;

  bank_state_e           bank_st [2];
  logic [1:0]            bank_err;
  logic [1:0]            take_wr, take_rd, done_wr, done_rd;
  logic                  wr_elig, rd_elig, wr_win, rd_win;
  logic                  keep_restore;

  // A grant in the previous cycle blocks both sides, enforcing 2-cycle config spacing.
  always_comb begin
    wr_elig = wr_req && (bank_st[wr_ptr_q] == BANK_EMPTY) && !(wr_grant_q || rd_grant_q);
    rd_elig = rd_req && (bank_st[rd_ptr_q] == BANK_FULL)  && !(wr_grant_q || rd_grant_q);
    wr_win  = wr_elig && !(rd_elig && rd_prio_q);
    rd_win  = rd_elig && !wr_win;
  end

`ifdef IMAGE_BANK_SCHED_REUSE_EN
  assign keep_restore = rd_done && rd_keep && (bank_st[rd_bank_q] == BANK_READING) && !rd_win;
`else
  assign keep_restore = 1'b0;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_prio_d   = rd_prio_q;
    wr_grant_d  = wr_win;
    rd_grant_d  = rd_win;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cfg_valid_d = wr_win || rd_win;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    err_d       = err_q || (|bank_err);

    // Priority only flips when both sides actually contended.
    if (wr_elig && rd_elig) rd_prio_d = !rd_prio_q;

    if (keep_restore) rd_ptr_d = rd_bank_q;

    if (wr_win) begin
      wr_bank_d  = wr_ptr_q;
      wr_ptr_d   = !wr_ptr_q;
      cfg_addr_d = WR_CFG_ADDR;
      cfg_data_d = CFG_DWIDTH'(wr_ptr_q);
    end else if (rd_win) begin
      rd_bank_d  = rd_ptr_q;
      rd_ptr_d   = !rd_ptr_q;
      cfg_addr_d = RD_CFG_ADDR;
      cfg_data_d = CFG_DWIDTH'(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rd_prio_q   <= 1'b0;
      wr_grant_q  <= 1'b0;
      rd_grant_q  <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_prio_q   <= rd_prio_d;
      wr_grant_q  <= wr_grant_d;
      rd_grant_q  <= rd_grant_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      err_q       <= err_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    assign take_wr[i]   = wr_win  && (wr_ptr_q  == 1'(i));
    assign take_rd[i]   = rd_win  && (rd_ptr_q  == 1'(i));
    assign done_wr[i]   = wr_done && (wr_bank_q == 1'(i));
    assign done_rd[i]   = rd_done && (rd_bank_q == 1'(i));
    assign bank_full[i] = (bank_st[i] == BANK_FULL) || (bank_st[i] == BANK_READING);

    image_bank_state u_state (
      .clk       (clk),
      .rst       (rst),
      .take_wr   (take_wr[i]),
      .done_wr   (done_wr[i]),
      .take_rd   (take_rd[i]),
      .done_rd   (done_rd[i]),
`ifdef IMAGE_BANK_SCHED_REUSE_EN
      .keep      (rd_keep),
`endif
      .state     (bank_st[i]),
      .err_pulse (bank_err[i])
    );
  end

  assign wr_grant  = wr_grant_q;
  assign rd_grant  = rd_grant_q;
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign err       = err_q;

endmodule
